// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg: register map, reset period and status layout for the GPIO input debouncer
package gpio_debounce_pkg;
   localparam logic ADDR_LIMIT = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;
   localparam logic [19:0] DEFAULT_LIMIT = 20'd100000;
   localparam int RISE_LSB = 0;
   localparam int FALL_LSB = 16;
endpackage

// File: rtl/gpio_debounce_chan.sv
// gpio_debounce_chan: two-flop synchroniser plus saturating debounce counter for one pin
module gpio_debounce_chan #(
   parameter int CW = 20
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pin,
   input  logic [CW-1:0] i_limit,
   output logic          o_level,
   output logic          o_rise,
   output logic          o_fall
);
   logic s1, s2, commit;
   logic [CW-1:0] cnt;
   assign commit = (s2 != o_level) && (cnt >= i_limit);
   assign o_rise = commit & s2;
   assign o_fall = commit & ~s2;
   always_ff @(posedge i_clk)
      if (i_reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         cnt <= '0;
         o_level <= 1'b0;
      end else begin
         s1 <= i_pin;
         s2 <= s1;
         if (s2 == o_level || commit) cnt <= '0;
         else if (cnt != '1) cnt <= cnt + 1'b1;
         if (commit) o_level <= s2;
      end
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin debouncer feeding the GPIO controller, with a 2-word Wishbone slave.
// Define GPIO_DEBOUNCE_EDGE_CAPTURE_EN for sticky rise/fall status (W1C) and a level interrupt.
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter int NIN = 16,
   parameter int CW = 20,
   parameter logic [CW-1:0] DEFAULT_LIMIT = gpio_debounce_pkg::DEFAULT_LIMIT
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_wb_cyc,
   input  logic           i_wb_stb,
   input  logic           i_wb_we,
   input  logic           i_wb_addr,
   input  logic [31:0]    i_wb_data,
   output logic           o_wb_ack,
   output logic           o_wb_stall,
   output logic [31:0]    o_wb_data,
   input  logic [NIN-1:0] i_pin,
   output logic [NIN-1:0] o_gpio,
   output logic           o_int
);
   logic [CW-1:0] limit;
   logic [NIN-1:0] rise_p, fall_p;
   logic [31:0] status;
   logic wr_limit;
   logic unused;
   assign unused = &{1'b0, i_wb_data};
   assign o_wb_stall = 1'b0;
   assign wr_limit = i_wb_cyc & i_wb_stb & i_wb_we & (i_wb_addr == ADDR_LIMIT);
   for (genvar i = 0; i < NIN; i++) begin : g_chan
      gpio_debounce_chan #(.CW(CW)) u_chan (
         .i_clk  (i_clk),
         .i_reset(i_reset),
         .i_pin  (i_pin[i]),
         .i_limit(limit),
         .o_level(o_gpio[i]),
         .o_rise (rise_p[i]),
         .o_fall (fall_p[i])
      );
   end
`ifdef GPIO_DEBOUNCE_EDGE_CAPTURE_EN
   logic [NIN-1:0] rise, fall, rise_nxt, fall_nxt, clr_rise, clr_fall;
   logic wr_status;
   // a commit landing with a W1C write on the same bit keeps the bit set
   always_comb begin
      wr_status = i_wb_cyc & i_wb_stb & i_wb_we & (i_wb_addr == ADDR_STATUS);
      clr_rise = wr_status ? i_wb_data[RISE_LSB +: NIN] : '0;
      clr_fall = wr_status ? i_wb_data[FALL_LSB +: NIN] : '0;
      rise_nxt = (rise & ~clr_rise) | rise_p;
      fall_nxt = (fall & ~clr_fall) | fall_p;
   end
   assign status = (32'(fall) << FALL_LSB) | (32'(rise) << RISE_LSB);
   always_ff @(posedge i_clk)
      if (i_reset) begin
         rise <= '0;
         fall <= '0;
         o_int <= 1'b0;
      end else begin
         rise <= rise_nxt;
         fall <= fall_nxt;
         o_int <= |{rise_nxt, fall_nxt};
      end
`else
   assign status = 32'(o_gpio);
   always_ff @(posedge i_clk)
      if (i_reset) o_int <= 1'b0;
      else o_int <= |{rise_p, fall_p};
`endif
   always_ff @(posedge i_clk)
      if (i_reset) begin
         limit <= DEFAULT_LIMIT;
         o_wb_ack <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack <= i_wb_stb;
         o_wb_data <= (i_wb_addr == ADDR_STATUS) ? status : 32'(limit);
         if (wr_limit) limit <= i_wb_data[CW-1:0];
      end
endmodule
